// File: rtl/ipg_wreq_tx.sv
// Transmit framer for IPG write requests: it places a 56-bit header chunk into one IPG slot,
// then sends the payload MSB-first, splitting it across the slot sizes offered each cycle.
module ipg_wreq_tx #(
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 16,
  parameter int ADR_WIDTH   = 40,
  parameter int LEN_WIDTH   = 6,
  parameter int PAYLOAD_LEN = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADR_WIDTH-1:0]   req_addr,
  input  logic [HDR_WIDTH-1:0]   req_len,
  input  logic [PAYLOAD_LEN-1:0] req_payload,
  input  logic [LEN_WIDTH-1:0]   ipg_slot_len,
  output logic [DATA_WIDTH-1:0]  tx_ipg_data,
  output logic [LEN_WIDTH-1:0]   tx_len,
  output logic                   wreq_valid,
  output logic                   tx_done,
  output logic                   req_err
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  localparam int PAD_W = DATA_WIDTH - HDR_WIDTH - ADR_WIDTH;
  localparam logic [LEN_WIDTH-1:0] HDR_CHUNK = LEN_WIDTH'(HDR_WIDTH + ADR_WIDTH);
  localparam logic [HDR_WIDTH-1:0] MAX_LEN   = HDR_WIDTH'(PAYLOAD_LEN);

  state_t                 state_q, state_d;
  logic                   req_ready_q, req_ready_d;
  logic                   wreq_valid_q, wreq_valid_d;
  logic                   tx_done_q, tx_done_d;
  logic                   req_err_q, req_err_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [LEN_WIDTH-1:0]   tx_len_q, tx_len_d;
  logic [PAYLOAD_LEN-1:0] sr_q, sr_d;
  logic [ADR_WIDTH-1:0]   addr_q, addr_d;
  logic [HDR_WIDTH-1:0]   len_q, len_d;
  logic [HDR_WIDTH-1:0]   rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   take_n;

  function automatic logic [LEN_WIDTH-1:0] chunk_take(input logic [LEN_WIDTH-1:0] slot,
                                                      input logic [HDR_WIDTH-1:0] rem);
    if (HDR_WIDTH'(slot) < rem) return slot;
    return rem[LEN_WIDTH-1:0];
  endfunction

  // Keeps the top n bits of a chunk; the rest must go out as zero.
  function automatic logic [DATA_WIDTH-1:0] chunk_mask(input logic [LEN_WIDTH-1:0] n);
    logic [7:0] drop;
    drop = 8'(DATA_WIDTH) - 8'(n);
    return {DATA_WIDTH{1'b1}} << drop;
  endfunction

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    addr_d       = addr_q;
    len_d        = len_q;
    rem_d        = rem_q;
    wreq_valid_d = 1'b0;
    tx_done_d    = 1'b0;
    req_err_d    = 1'b0;
    tx_data_d    = '0;
    tx_len_d     = '0;
    take_n       = chunk_take(ipg_slot_len, rem_q);
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_len == '0 || req_len > MAX_LEN) begin
            req_err_d = 1'b1;
          end else begin
            state_d = HDR;
            addr_d  = req_addr;
            len_d   = req_len;
            rem_d   = req_len;
            sr_d    = req_payload << (MAX_LEN - req_len);
          end
        end
      end
      HDR: begin
        // The header is never split: slots too small for it are simply left unused.
        if (ipg_slot_len >= HDR_CHUNK) begin
          tx_data_d    = {len_q, addr_q, {PAD_W{1'b0}}};
          tx_len_d     = HDR_CHUNK;
          wreq_valid_d = 1'b1;
          state_d      = DATA;
        end
      end
      DATA: begin
        if (ipg_slot_len != '0) begin
          tx_data_d    = sr_q[PAYLOAD_LEN-1 -: DATA_WIDTH] & chunk_mask(take_n);
          tx_len_d     = take_n;
          wreq_valid_d = 1'b1;
          sr_d         = sr_q << take_n;
          rem_d        = rem_q - HDR_WIDTH'(take_n);
          if (rem_d == '0) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      wreq_valid_q <= 1'b0;
      tx_done_q    <= 1'b0;
      req_err_q    <= 1'b0;
      tx_data_q    <= '0;
      tx_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      wreq_valid_q <= wreq_valid_d;
      tx_done_q    <= tx_done_d;
      req_err_q    <= req_err_d;
      tx_data_q    <= tx_data_d;
      tx_len_q     <= tx_len_d;
    end
  end

  // Request datapath: only meaningful while HDR/DATA, so it is not reset.
  always_ff @(posedge clk) begin
    sr_q   <= sr_d;
    addr_q <= addr_d;
    len_q  <= len_d;
    rem_q  <= rem_d;
  end

  assign req_ready   = req_ready_q;
  assign wreq_valid  = wreq_valid_q;
  assign tx_done     = tx_done_q;
  assign req_err     = req_err_q;
  assign tx_ipg_data = tx_data_q;
  assign tx_len      = tx_len_q;

endmodule

// File: tb/tb_ipg_wreq_tx.sv
// Randomised scoreboard bench for ipg_wreq_tx: a bit-queue reference model predicts each chunk,
// and a negedge monitor compares every chunk or error pulse against the predictions.
module tb_ipg_wreq_tx;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [39:0]  req_addr = '0;
  logic [15:0]  req_len = '0;
  logic [511:0] req_payload = '0;
  logic [5:0]   ipg_slot_len = '0;
  logic [63:0]  tx_ipg_data;
  logic [5:0]   tx_len;
  logic         wreq_valid, tx_done, req_err;

  ipg_wreq_tx dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .req_payload(req_payload),
    .ipg_slot_len(ipg_slot_len), .tx_ipg_data(tx_ipg_data), .tx_len(tx_len),
    .wreq_valid(wreq_valid), .tx_done(tx_done), .req_err(req_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [5:0]  len;
    logic        done;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          phase = 0;   // 0 idle, 1 header pending, 2 payload pending
  logic [63:0] hdr_word;
  bit          pbits[$];    // payload bits still to send, first-sent at front

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what one sampled slot should produce.
  task automatic model_slot(input int s);
    exp_t e;
    int   n;
    if (phase == 1 && s >= 56) begin
      e.data = hdr_word; e.len = 6'd56; e.done = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      phase = 2;
    end else if (phase == 2 && s > 0) begin
      n = (s < pbits.size()) ? s : pbits.size();
      e.data = '0;
      for (int i = 0; i < n; i++) e.data[63-i] = pbits.pop_front();
      e.len = 6'(n); e.err = 1'b0;
      e.done = (pbits.size() == 0);
      sb.push_back(e);
      if (e.done) phase = 0;
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the next posedge.
  task automatic drive(input int s);
    ipg_slot_len = 6'(s);
    model_slot(s);
    @(posedge clk); #1;
    ipg_slot_len = '0;
  endtask

  task automatic send(input logic [39:0] a, input logic [15:0] l, input logic [511:0] p);
    exp_t e;
    int   cnt;
    req_addr = a; req_len = l; req_payload = p; req_valid = 1'b1;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (req_ready) break;
      cnt++;
      if (cnt > 200) begin
        chk("ready_timeout", 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (l == 0 || l > 512) begin
      e.data = '0; e.len = '0; e.done = 1'b0; e.err = 1'b1;
      sb.push_back(e);
      phase = 0;
      @(negedge clk);
      chk("ready_after_err", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
    end else begin
      hdr_word = {l, a, 8'h00};
      pbits.delete();
      for (int i = int'(l) - 1; i >= 0; i--) pbits.push_back(p[i]);
      phase = 1;
    end
  endtask

  task automatic run_rand(input int lo, input int hi);
    int guard = 0;
    while (phase != 0 && guard < 3000) begin
      drive($urandom_range(hi, lo));
      guard++;
    end
  endtask

  function automatic logic [511:0] rand_payload();
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[i*32 +: 32] = $urandom();
    return p;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && (wreq_valid || tx_done || req_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", {tx_len, wreq_valid, tx_done, req_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("valid", 64'(wreq_valid), 64'(!e.err));
        chk("data", tx_ipg_data, e.data);
        chk("len", 64'(tx_len), 64'(e.len));
        chk("done", 64'(tx_done), 64'(e.done));
        chk("err", 64'(req_err), 64'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] p;
    // Reset state
    @(negedge clk);
    chk("rst_valid", 64'(wreq_valid), 64'd0);
    chk("rst_data", tx_ipg_data, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_before_clk", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_clk", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 64-bit payload with 63-bit slots: header, then 63 + 1 bit chunks
    send(40'h12_3456_789A, 16'd64, rand_payload());
    while (phase != 0) drive(63);

    // 8-bit payload with a slot too small for the header and a zero slot mid-payload
    p = '0; p[7:0] = 8'hA5;
    send(40'h00_0000_0001, 16'd8, p);
    drive(40); drive(56); drive(3); drive(0); drive(5);

    // Bad lengths are dropped
    send(40'h55, 16'd0, rand_payload());
    send(40'h66, 16'd600, rand_payload());
    send(40'h77, 16'd513, rand_payload());

    // Full-size payloads with random slots
    for (int k = 0; k < 3; k++) begin
      send({$urandom(), 8'($urandom())}, 16'd512, rand_payload());
      run_rand(1, 63);
    end
    // Random lengths, slots including 0 and sub-header sizes
    for (int k = 0; k < 8; k++) begin
      send({$urandom(), 8'($urandom())}, 16'($urandom_range(512, 1)), rand_payload());
      run_rand(0, 63);
    end

    // req_valid held with a different request while busy
    send(40'hAA_BBBB_CCCC, 16'd100, rand_payload());
    p = rand_payload();
    req_valid = 1'b1; req_addr = 40'h11_2222_3333; req_len = 16'd77; req_payload = p;
    run_rand(0, 63);
    send(40'h11_2222_3333, 16'd77, p);
    run_rand(1, 63);

    // Reset while in the middle of a payload
    send(40'hDE_ADBE_EF01, 16'd512, rand_payload());
    drive(56); drive(10); drive(10);
    @(negedge clk); #2;
    reset = 1'b1;
    ipg_slot_len = 6'd20;
    #1;
    chk("mid_rst_valid", 64'(wreq_valid), 64'd0);
    chk("mid_rst_data", tx_ipg_data, 64'd0);
    chk("mid_rst_len", 64'(tx_len), 64'd0);
    phase = 0;
    pbits.delete();
    @(posedge clk); #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_valid2", 64'(wreq_valid), 64'd0);
    reset = 1'b0;
    ipg_slot_len = '0;
    @(negedge clk);
    chk("post_rst_ready0", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("post_rst_ready1", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    send(40'h01_0203_0405, 16'd200, rand_payload());
    run_rand(1, 63);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
